henad_trace_tx: RTL and testbench

Hardware trace transmitter for the Henad core. It captures every retired instruction's PC and instruction word from the final pipeline stage into a small FIFO. It then serializes each entry as a framed byte stream over a UART 8N1 line, so pipeline flow can be observed on silicon and FPGA as well as in simulation. It sits beside `henad`, fed from the FINAL-stage registers.

---
 rtl/henad_trace_tx.sv | 170 +++++++++++++++++
 tb/tb_henad_trace_tx.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/henad_trace_tx.sv
// Henad retired-instruction trace transmitter: FIFO of {pc, instr} entries sent as framed UART 8N1 bytes.
// Optional checksum byte (XOR of PC and instruction bytes) enabled by defining HENAD_TRACE_CHECKSUM_EN.
module henad_trace_tx #(
    parameter int ADDR_W       = 24,
    parameter int INSTR_W      = 24,
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 69
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          trace_valid,
    input  logic [ADDR_W-1:0]             trace_pc,
    input  logic [INSTR_W-1:0]            trace_instr,
    output logic                          uart_tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_W + INSTR_W;
`ifdef HENAD_TRACE_CHECKSUM_EN
    localparam int NBYTES  = 2 + ENTRY_W / 8;
`else
    localparam int NBYTES  = 1 + ENTRY_W / 8;
`endif
    localparam int FRAME_W = 8 * NBYTES;
    localparam int BYTE_W  = $clog2(NBYTES);
    localparam int BAUD_W  = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // FIFO storage and bookkeeping
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               full, push, pop;
    logic [ENTRY_W-1:0] head;

    assign full = (count == CNT_W'(FIFO_DEPTH));
    assign push = trace_valid && (!full || pop);
    assign head = mem[rd_ptr];
    assign fifo_count = count;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {trace_pc, trace_instr};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (trace_valid && !push) overflow <= 1'b1;
        end
    end

    // Frame image loaded into a shift register; the current byte is always the top 8 bits
    logic [FRAME_W-1:0] load_frame;
`ifdef HENAD_TRACE_CHECKSUM_EN
    logic [7:0] csum;
    always_comb begin
        csum = '0;
        for (int unsigned i = 0; i < ENTRY_W / 8; i++) csum ^= head[8*i +: 8];
        load_frame = {8'hA5, head, csum};
    end
`else
    assign load_frame = {8'hA5, head};
`endif

    state_t             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [BYTE_W-1:0]  byte_q, byte_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               baud_end;
    logic [7:0]         cur_d;

    assign baud_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + BAUD_W'(1);
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (count != '0) begin
                    pop     = 1'b1;
                    shift_d = load_frame;
                    byte_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (byte_q == BYTE_W'(NBYTES - 1)) begin
                        state_d = IDLE;
                    end else begin
                        byte_d  = byte_q + BYTE_W'(1);
                        shift_d = shift_q << 8;
                        state_d = START;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is derived from the next state so uart_tx stays a clean register output
    always_comb begin
        cur_d = shift_d[FRAME_W-1 -: 8];
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_d[bit_d];
            default: tx_d = 1'b1;
        endcase
        busy = (state_q != IDLE);
    end

    assign uart_tx = tx_q;

endmodule

// File: tb/tb_henad_trace_tx.sv
// Directed bench for henad_trace_tx: mid-bit UART monitor, byte scoreboard, timing and overflow checks.
module tb_henad_trace_tx;
    localparam int CPB = 4;
    localparam int DEPTH = 8;
    localparam int AW = 24;
    localparam int IW = 24;
`ifdef HENAD_TRACE_CHECKSUM_EN
    localparam int NB = 8;
`else
    localparam int NB = 7;
`endif
    localparam int FRAME_CYC = 10 * NB * CPB;

    logic          clk = 1'b0;
    logic          rst;
    logic          trace_valid;
    logic [AW-1:0] trace_pc;
    logic [IW-1:0] trace_instr;
    logic          uart_tx;
    logic          busy;
    logic          overflow;
    logic [3:0]    fifo_count;

    henad_trace_tx #(
        .ADDR_W(AW),
        .INSTR_W(IW),
        .FIFO_DEPTH(DEPTH),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .trace_valid(trace_valid),
        .trace_pc(trace_pc),
        .trace_instr(trace_instr),
        .uart_tx(uart_tx),
        .busy(busy),
        .overflow(overflow),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         got_t[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_frame(input logic [AW-1:0] pc, input logic [IW-1:0] ins);
        logic [47:0] e;
        logic [7:0]  b;
        logic [7:0]  x;
        e = {pc, ins};
        x = 8'h00;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 6; i++) begin
            b = e[47-8*i -: 8];
            exp_q.push_back(b);
            x ^= b;
        end
`ifdef HENAD_TRACE_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic push(input logic [AW-1:0] pc, input logic [IW-1:0] ins, output int at);
        trace_valid = 1'b1;
        trace_pc    = pc;
        trace_instr = ins;
        @(negedge clk);
        trace_valid = 1'b0;
        at = cyc;
    endtask

    task automatic wait_bytes(input int n, input string tag);
        int k;
        k = 0;
        while (got_q.size() < n && k < 6000) begin
            @(negedge clk);
            k++;
        end
        check(tag, got_q.size(), n);
    endtask

    task automatic wait_busy(input logic lvl, output int at);
        int k;
        k = 0;
        while (busy !== lvl && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("wait_busy", busy, lvl);
        at = cyc;
    endtask

    task automatic compare_bytes(input string tag);
        while (exp_q.size() > 0) begin
            if (got_q.size() == 0) begin
                check({tag, "_missing"}, exp_q.size(), 0);
                exp_q.delete();
            end else begin
                check(tag, got_q.pop_front(), exp_q.pop_front());
                void'(got_t.pop_front());
            end
        end
        check({tag, "_extra"}, got_q.size(), 0);
    endtask

    // UART monitor: detect start edge, sample each bit mid-period, discard bytes cut by reset
    int         mon_st;
    logic [7:0] mon_d;
    logic       mon_sb, mon_sp, mon_abort;

    task automatic mon_step(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (rst) mon_abort = 1'b1;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && uart_tx === 1'b0) begin
                mon_st    = cyc;
                mon_abort = 1'b0;
                mon_step(2);
                mon_sb = uart_tx;
                for (int j = 0; j < 8; j++) begin
                    mon_step(4);
                    mon_d[j] = uart_tx;
                end
                mon_step(4);
                mon_sp = uart_tx;
                if (!mon_abort) begin
                    check("start_bit", mon_sb, 1'b0);
                    check("stop_bit", mon_sp, 1'b1);
                    got_q.push_back(mon_d);
                    got_t.push_back(mon_st);
                end
            end
        end
    end

    int p, s, done, t0, t1, t2;

    initial begin
        rst = 1'b1;
        trace_valid = 1'b0;
        trace_pc = '0;
        trace_instr = '0;
        repeat (2) @(negedge clk);
        check("rst_tx", uart_tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_cnt", fifo_count, 4'd0);
        rst = 1'b0;
        @(negedge clk);

        // single entry, hand-computed bytes
        push(24'h000123, 24'hABCDEF, p);
        exp_q = '{8'hA5, 8'h00, 8'h01, 8'h23, 8'hAB, 8'hCD, 8'hEF};
`ifdef HENAD_TRACE_CHECKSUM_EN
        exp_q.push_back(8'hAB);
`endif
        wait_busy(1'b1, s);
        wait_busy(1'b0, done);
        wait_bytes(NB, "single_nbytes");
        if (got_t.size() > 0) begin
            check("start_latency", got_t[0], p + 1);
            check("frame_len", done - got_t[0], FRAME_CYC);
        end
        compare_bytes("single_byte");
        check("single_cnt", fifo_count, 4'd0);
        repeat (5) @(negedge clk);

        // three back-to-back entries
        for (int k = 1; k <= 3; k++) begin
            trace_valid = 1'b1;
            trace_pc = AW'(k);
            trace_instr = 24'h5A0000 + IW'(k);
            expect_frame(AW'(k), 24'h5A0000 + IW'(k));
            @(negedge clk);
        end
        trace_valid = 1'b0;
        wait_bytes(3 * NB, "b2b_nbytes");
        if (got_t.size() >= 2 * NB + 1) begin
            t0 = got_t[0];
            t1 = got_t[NB];
            t2 = got_t[2*NB];
            check("b2b_gap1", t1 - t0, FRAME_CYC + 1);
            check("b2b_gap2", t2 - t1, FRAME_CYC + 1);
        end
        compare_bytes("b2b_byte");
        check("b2b_ovf", overflow, 1'b0);
        repeat (5) @(negedge clk);

        // overflow: 10 consecutive pushes, the last is dropped
        for (int k = 0; k < 10; k++) begin
            trace_valid = 1'b1;
            trace_pc = 24'h000100 + AW'(k);
            trace_instr = 24'hC30000 + IW'(k);
            if (k < 9) expect_frame(24'h000100 + AW'(k), 24'hC30000 + IW'(k));
            @(negedge clk);
        end
        trace_valid = 1'b0;
        check("ovf_flag", overflow, 1'b1);
        check("ovf_cnt", fifo_count, 4'd8);
        wait_bytes(9 * NB, "ovf_nbytes");
        compare_bytes("ovf_byte");
        repeat (5) @(negedge clk);
        check("ovf_drain_cnt", fifo_count, 4'd0);
        check("ovf_sticky", overflow, 1'b1);

        // reset during DATA of byte 2, with a second entry still queued
        push(24'h000123, 24'hABCDEF, p);
        push(24'h000456, 24'h111111, s);
        s = p + 1;
        while (cyc < s + 90 && cyc < p + 1000) @(negedge clk);
        check("pre_rst_tx", uart_tx, 1'b0);
        check("pre_rst_cnt", fifo_count, 4'd1);
        got_q.delete();
        got_t.delete();
        exp_q.delete();
        rst = 1'b1;
        #1;
        check("mid_rst_tx", uart_tx, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_cnt", fifo_count, 4'd0);
        check("mid_rst_ovf", overflow, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("post_rst_frames", got_q.size(), 0);
        check("post_rst_tx", uart_tx, 1'b1);
        push(24'h00BEEF, 24'h123456, p);
        expect_frame(24'h00BEEF, 24'h123456);
        wait_bytes(NB, "post_rst_nbytes");
        if (got_t.size() > 0) check("post_rst_lat", got_t[0], p + 1);
        compare_bytes("post_rst_byte");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
